// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage combining the MEM/WB pipeline register,
// the writeback-source mux and a load-return wait state machine.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   handshake from the memory stage
//   in_wb_sel           writeback source (PCInc, Cond, ReadData, ALU, Imm)
//   in_reg_wr_en/in_wr  register write enable / destination
//   in_pc_inc, in_cond, in_alu, in_imm  candidate writeback values
//   ld_valid/ld_data    load return
//   flush               squash the held or waiting entry
//   rf_we/rf_wr/rf_wd   register-file write port
//   pend_valid/pend_wr  pending-load hazard indication for decode
//   retire_count        retired instruction count (wraps)
//   err                 sticky illegal-select flag
//
// state   | meaning
// EMPTY   | no entry held
// FULL    | entry resolved, written to the register file this cycle
// WAIT_LD | load accepted, read data not yet returned
module wb_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_wb_sel,
  input  logic              in_reg_wr_en,
  input  logic [REG_AW-1:0] in_wr,
  input  logic [DATA_W-1:0] in_pc_inc,
  input  logic              in_cond,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_wr,
  output logic [CNT_W-1:0]  retire_count,
  output logic              err
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    WAIT_LD = 2'd2
  } stateT;

  localparam logic [2:0] SEL_PC   = 3'b000;
  localparam logic [2:0] SEL_COND = 3'b001;
  localparam logic [2:0] SEL_LOAD = 3'b010;
  localparam logic [2:0] SEL_ALU  = 3'b011;
  localparam logic [2:0] SEL_IMM  = 3'b100;

  stateT             state;
  logic              entryWrEn;
  logic [REG_AW-1:0] entryWr;
  logic [DATA_W-1:0] entryData;
  logic [CNT_W-1:0]  retireCnt;
  logic              errFlag;

  logic              accept;
  logic              selIllegal;
  logic              isLoad;
  logic [DATA_W-1:0] muxData;

  assign in_ready = !flush && (state != WAIT_LD);
  assign accept   = in_valid && in_ready;
  assign isLoad   = (in_wb_sel == SEL_LOAD);

  // Illegal selects resolve to zero; the entry still retires, just without a write.
  always_comb begin
    muxData    = '0;
    selIllegal = 1'b0;
    case (in_wb_sel)
      SEL_PC:   muxData = in_pc_inc;
      SEL_COND: muxData = {{(DATA_W-1){1'b0}}, in_cond};
      SEL_LOAD: muxData = ld_data;
      SEL_ALU:  muxData = in_alu;
      SEL_IMM:  muxData = in_imm;
      default:  selIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      entryWrEn <= 1'b0;
      entryWr   <= '0;
      entryData <= '0;
      retireCnt <= '0;
      errFlag   <= 1'b0;
    end else begin
      if (state == FULL) begin
        retireCnt <= retireCnt + CNT_W'(1);
      end
      // accept already implies !flush, so a flush never races a new entry.
      if (accept) begin
        entryWr   <= in_wr;
        entryWrEn <= in_reg_wr_en && !selIllegal;
        entryData <= muxData;
        if (selIllegal) begin
          errFlag <= 1'b1;
        end
        state <= (isLoad && !ld_valid) ? WAIT_LD : FULL;
      end else if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          FULL: state <= EMPTY;
          WAIT_LD: begin
            if (ld_valid) begin
              entryData <= ld_data;
              state     <= FULL;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  assign rf_we        = (state == FULL) && entryWrEn;
  assign rf_wr        = (state == FULL) ? entryWr : '0;
  assign rf_wd        = (state == FULL) ? entryData : '0;
  assign pend_valid   = (state == WAIT_LD) && entryWrEn;
  assign pend_wr      = (state == WAIT_LD) ? entryWr : '0;
  assign retire_count = retireCnt;
  assign err          = errFlag;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_wb_sel;
  logic        in_reg_wr_en;
  logic [2:0]  in_wr;
  logic [15:0] in_pc_inc;
  logic        in_cond;
  logic [15:0] in_alu;
  logic [15:0] in_imm;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        flush;

  logic        in_ready, rf_we, pend_valid, err;
  logic [2:0]  rf_wr, pend_wr;
  logic [15:0] rf_wd, retire_count;

  logic        sReady, sWe, sPend, sErr;
  logic [2:0]  sWr, sPendWr;
  logic [15:0] sWd;
  logic [1:0]  sCount;

  int total = 0;
  int bad   = 0;

  // behavioural model of the held entry
  bit          mFull, mWait, mWe, mErr;
  logic [2:0]  mWr;
  logic [15:0] mData;
  int unsigned mCount;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic        wrEn;
    logic [2:0]  wr;
    logic [15:0] pcInc;
    logic        cond;
    logic [15:0] alu;
    logic [15:0] imm;
    logic        ldV;
    logic [15:0] ldD;
    logic        fl;
    logic        eReady;
    logic        eWe;
    logic [2:0]  eWr;
    logic [15:0] eWd;
    logic        ePend;
    logic [2:0]  ePendWr;
  } vecT;

  vecT tbl[16];

  always #5 clk = ~clk;

  wb_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_sel(in_wb_sel), .in_reg_wr_en(in_reg_wr_en), .in_wr(in_wr),
    .in_pc_inc(in_pc_inc), .in_cond(in_cond), .in_alu(in_alu), .in_imm(in_imm),
    .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .pend_valid(pend_valid), .pend_wr(pend_wr),
    .retire_count(retire_count), .err(err)
  );

  wb_stage_pipe #(.DATA_W(16), .REG_AW(3), .CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sReady),
    .in_wb_sel(in_wb_sel), .in_reg_wr_en(in_reg_wr_en), .in_wr(in_wr),
    .in_pc_inc(in_pc_inc), .in_cond(in_cond), .in_alu(in_alu), .in_imm(in_imm),
    .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
    .rf_we(sWe), .rf_wr(sWr), .rf_wd(sWd),
    .pend_valid(sPend), .pend_wr(sPendWr),
    .retire_count(sCount), .err(sErr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vecT mk(input logic valid, input logic [2:0] sel, input logic wrEn,
                             input logic [2:0] wr, input logic [15:0] data, input logic cond,
                             input logic ldV, input logic [15:0] ldD, input logic fl,
                             input logic eReady, input logic eWe, input logic [2:0] eWr,
                             input logic [15:0] eWd, input logic ePend, input logic [2:0] ePendWr);
    vecT v;
    v.valid = valid; v.sel = sel; v.wrEn = wrEn; v.wr = wr;
    v.pcInc = (sel == 3'd0) ? data : 16'hA0A0;
    v.alu   = (sel == 3'd3) ? data : 16'hB1B1;
    v.imm   = (sel == 3'd4) ? data : 16'hC2C2;
    v.cond  = cond; v.ldV = ldV; v.ldD = ldD; v.fl = fl;
    v.eReady = eReady; v.eWe = eWe; v.eWr = eWr; v.eWd = eWd;
    v.ePend = ePend; v.ePendWr = ePendWr;
    return v;
  endfunction

  task automatic drive(input vecT v);
    in_valid = v.valid; in_wb_sel = v.sel; in_reg_wr_en = v.wrEn; in_wr = v.wr;
    in_pc_inc = v.pcInc; in_cond = v.cond; in_alu = v.alu; in_imm = v.imm;
    ld_valid = v.ldV; ld_data = v.ldD; flush = v.fl;
  endtask

  task automatic modelReset();
    mFull = 0; mWait = 0; mWe = 0; mErr = 0; mWr = '0; mData = '0; mCount = 0;
  endtask

  // One clock of the writeback rules, evaluated on the currently driven inputs.
  task automatic modelStep();
    bit nFull, nWait;
    bit ready;
    ready  = !flush && !mWait;
    nFull  = mFull;
    nWait  = mWait;
    if (mFull) mCount = mCount + 1;
    if (in_valid && ready) begin
      mWr = in_wr;
      mWe = in_reg_wr_en;
      nFull = 1; nWait = 0;
      case (in_wb_sel)
        3'd0: mData = in_pc_inc;
        3'd1: mData = in_cond ? 16'd1 : 16'd0;
        3'd2: begin
          if (ld_valid) mData = ld_data;
          else begin nFull = 0; nWait = 1; end
        end
        3'd3: mData = in_alu;
        3'd4: mData = in_imm;
        default: begin mData = 16'd0; mWe = 0; mErr = 1; end
      endcase
    end else if (flush) begin
      nFull = 0; nWait = 0;
    end else if (mFull) begin
      nFull = 0;
    end else if (mWait && ld_valid) begin
      mData = ld_data; nWait = 0; nFull = 1;
    end
    mFull = nFull;
    mWait = nWait;
  endtask

  task automatic checkModel();
    chk("rf_we",        rf_we,        mFull && mWe);
    chk("rf_wr",        rf_wr,        mFull ? mWr : 3'd0);
    chk("rf_wd",        rf_wd,        mFull ? mData : 16'd0);
    chk("pend_valid",   pend_valid,   mWait && mWe);
    chk("pend_wr",      pend_wr,      mWait ? mWr : 3'd0);
    chk("retire_count", retire_count, mCount % 65536);
    chk("err",          err,          mErr);
    chk("small_count",  sCount,       mCount % 4);
  endtask

  task automatic runCycle(input vecT v, input bit useTbl, input int idx);
    drive(v);
    #1;
    chk("in_ready", in_ready, !flush && !mWait);
    if (useTbl) chk($sformatf("tbl%0d_ready", idx), in_ready, v.eReady);
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
    if (useTbl) begin
      chk($sformatf("tbl%0d_we", idx),     rf_we,      v.eWe);
      chk($sformatf("tbl%0d_wr", idx),     rf_wr,      v.eWr);
      chk($sformatf("tbl%0d_wd", idx),     rf_wd,      v.eWd);
      chk($sformatf("tbl%0d_pend", idx),   pend_valid, v.ePend);
      chk($sformatf("tbl%0d_pendwr", idx), pend_wr,    v.ePendWr);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_ready"},  in_ready,     1);
    chk({tag, "_we"},     rf_we,        0);
    chk({tag, "_wr"},     rf_wr,        0);
    chk({tag, "_wd"},     rf_wd,        0);
    chk({tag, "_pend"},   pend_valid,   0);
    chk({tag, "_pendwr"}, pend_wr,      0);
    chk({tag, "_count"},  retire_count, 0);
    chk({tag, "_err"},    err,          0);
  endtask

  initial begin
    vecT v;
    vecT idle;
    idle = mk(0, 3'd0, 0, 3'd0, 16'h0, 0, 0, 16'h0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0);

    //              vld sel  we wr    data      c ldv ldD       fl | rdy we wr    wd        pd pwr
    tbl[0]  = mk(1, 3'd3, 1, 3'd5, 16'h1234, 0, 0, 16'h0000, 0,  1, 1, 3'd5, 16'h1234, 0, 3'd0);
    tbl[1]  = mk(1, 3'd1, 1, 3'd2, 16'h0000, 1, 0, 16'h0000, 0,  1, 1, 3'd2, 16'h0001, 0, 3'd0);
    tbl[2]  = mk(1, 3'd0, 1, 3'd4, 16'h0042, 0, 0, 16'h0000, 0,  1, 1, 3'd4, 16'h0042, 0, 3'd0);
    tbl[3]  = mk(1, 3'd2, 1, 3'd3, 16'h0000, 0, 0, 16'h1111, 0,  1, 0, 3'd0, 16'h0000, 1, 3'd3);
    tbl[4]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 3'd0, 16'h0000, 1, 3'd3);
    tbl[5]  = mk(1, 3'd3, 1, 3'd6, 16'h9999, 0, 0, 16'h0000, 0,  0, 0, 3'd0, 16'h0000, 1, 3'd3);
    tbl[6]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 3'd0, 16'h0000, 1, 3'd3);
    tbl[7]  = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 1, 16'hBEEF, 0,  0, 1, 3'd3, 16'hBEEF, 0, 3'd0);
    tbl[8]  = mk(1, 3'd2, 1, 3'd6, 16'h0000, 0, 1, 16'h00AA, 0,  1, 1, 3'd6, 16'h00AA, 0, 3'd0);
    tbl[9]  = mk(1, 3'd2, 1, 3'd1, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 3'd0, 16'h0000, 1, 3'd1);
    tbl[10] = mk(1, 3'd3, 1, 3'd2, 16'h4444, 0, 0, 16'h0000, 1,  0, 0, 3'd0, 16'h0000, 0, 3'd0);
    tbl[11] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 1, 16'h5555, 0,  1, 0, 3'd0, 16'h0000, 0, 3'd0);
    tbl[12] = mk(1, 3'd6, 1, 3'd2, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 3'd2, 16'h0000, 0, 3'd0);
    tbl[13] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 0,  1, 0, 3'd0, 16'h0000, 0, 3'd0);
    tbl[14] = mk(1, 3'd3, 1, 3'd7, 16'h7777, 0, 0, 16'h0000, 0,  1, 1, 3'd7, 16'h7777, 0, 3'd0);
    tbl[15] = mk(0, 3'd0, 0, 3'd0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 3'd0, 16'h0000, 0, 3'd0);

    rst = 1'b1;
    drive(idle);
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) runCycle(tbl[i], 1'b1, i);
    chk("err_sticky", err, 1);

    // reset asserted asynchronously while a load is waiting
    v = mk(1, 3'd2, 1, 3'd4, 16'h0, 0, 0, 16'h0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0);
    runCycle(v, 1'b0, 0);
    chk("pre_rst_pend", pend_valid, 1);
    drive(idle);
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    chk("async_rst_small", sCount, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // five back-to-back retires wrap the 2-bit counter to 1
    for (int i = 0; i < 5; i++) begin
      v = mk(1, 3'd3, 1, 3'(i), 16'(i * 3 + 1), 0, 0, 16'h0, 0, 0, 0, 3'd0, 16'h0, 0, 3'd0);
      runCycle(v, 1'b0, 0);
    end
    runCycle(idle, 1'b0, 0);
    chk("small_wrap", sCount, 2'd1);
    chk("big_five", retire_count, 16'd5);

    for (int i = 0; i < 400; i++) begin
      v.valid = ($urandom_range(0, 3) != 0);
      v.sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      v.wrEn  = ($urandom_range(0, 4) != 0);
      v.wr    = 3'($urandom);
      v.pcInc = 16'($urandom);
      v.cond  = 1'($urandom);
      v.alu   = 16'($urandom);
      v.imm   = 16'($urandom);
      v.ldV   = ($urandom_range(0, 2) == 0);
      v.ldD   = 16'($urandom);
      v.fl    = ($urandom_range(0, 9) == 0);
      runCycle(v, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
